// File: rtl/otter_regfile_dumper_pkg.sv
// Shared widths and FSM state type for the OTTER register-file dump engine.
// The CKSUM state exists only when OTTER_DUMP_CHECKSUM_EN is defined.
package otter_dbg_pkg;
  localparam int RF_ADDR_W = 5;
  localparam int RF_DATA_W = 32;

`ifdef OTTER_DUMP_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, FETCH, SEND, FIN, CKSUM} dump_state_t;
`else
  typedef enum logic [1:0] {IDLE, FETCH, SEND, FIN} dump_state_t;
`endif
endpackage

// File: rtl/otter_regfile_dumper_if.sv
// Command, register-file read port and output stream of the dump engine.
// The slave modport is the dumper side; master is the debug/trace side.
interface otter_regfile_dumper_if
  import otter_dbg_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W
);
  logic              START;
  logic [ADDR_W-1:0] START_FIRST;
  logic [ADDR_W-1:0] START_LAST;
  logic              ABORT;
  logic [ADDR_W-1:0] RF_ADDR;
  logic [DATA_W-1:0] RF_DATA;
  logic              DOUT_VALID;
  logic              DOUT_READY;
  logic [DATA_W-1:0] DOUT_DATA;
  logic [ADDR_W-1:0] DOUT_IDX;
  logic              DOUT_LAST;
  logic              BUSY;
  logic              DONE;

  modport slave (
    input  START, START_FIRST, START_LAST, ABORT, RF_DATA, DOUT_READY,
    output RF_ADDR, DOUT_VALID, DOUT_DATA, DOUT_IDX, DOUT_LAST, BUSY, DONE
  );

  modport master (
    output START, START_FIRST, START_LAST, ABORT, RF_DATA, DOUT_READY,
    input  RF_ADDR, DOUT_VALID, DOUT_DATA, DOUT_IDX, DOUT_LAST, BUSY, DONE
  );
endinterface

// File: rtl/otter_stream_reg.sv
// Output beat register: captures a beat on load and holds it until accepted.
// Flush drops a pending beat immediately.
module otter_stream_reg
  import otter_dbg_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_load,
  input  logic              i_accept,
  input  logic              i_flush,
  input  logic [DATA_W-1:0] i_data,
  input  logic [ADDR_W-1:0] i_idx,
  input  logic              i_last,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic [ADDR_W-1:0] o_idx,
  output logic              o_last
);
  logic              r_valid;
  logic [DATA_W-1:0] r_data;
  logic [ADDR_W-1:0] r_idx;
  logic              r_last;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_idx   <= '0;
      r_last  <= 1'b0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
      r_idx   <= i_idx;
      r_last  <= i_last;
    end else if (i_accept) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_idx   = r_idx;
  assign o_last  = r_last;
endmodule

// File: rtl/otter_regfile_dumper.sv
// Walks a register index range through one read port and streams each value out.
// OTTER_DUMP_CHECKSUM_EN appends an XOR checksum beat after the register beats.
module otter_regfile_dumper
  import otter_dbg_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W
) (
  input logic                   CLK,
  input logic                   RST_N,
  otter_regfile_dumper_if.slave bus
);
  dump_state_t       r_state;
  dump_state_t       w_next;
  logic [ADDR_W-1:0] r_cur;
  logic [ADDR_W-1:0] r_end;
  logic              r_done;
  logic              w_accept;
  logic              w_final;
  logic              w_load;
  logic              w_latch;
  logic              w_inc;
  logic [DATA_W-1:0] w_ld_data;
  logic [ADDR_W-1:0] w_ld_idx;
  logic              w_ld_last;
`ifdef OTTER_DUMP_CHECKSUM_EN
  logic [DATA_W-1:0] r_acc;
`endif

  assign w_accept = bus.DOUT_VALID & bus.DOUT_READY;
  assign w_final  = (r_cur == r_end);

  always_comb begin
    w_next    = r_state;
    w_load    = 1'b0;
    w_latch   = 1'b0;
    w_inc     = 1'b0;
    w_ld_data = bus.RF_DATA;
    w_ld_idx  = r_cur;
`ifdef OTTER_DUMP_CHECKSUM_EN
    w_ld_last = 1'b0;
`else
    w_ld_last = w_final;
`endif
    unique case (r_state)
      IDLE: begin
        if (bus.START) begin
          w_latch = 1'b1;
          w_next  = FETCH;
        end
      end
      FETCH: begin
        w_load = 1'b1;
        w_next = SEND;
      end
      SEND: begin
        if (w_accept) begin
          if (w_final) begin
`ifdef OTTER_DUMP_CHECKSUM_EN
            w_next = CKSUM;
`else
            w_next = FIN;
`endif
          end else begin
            w_inc  = 1'b1;
            w_next = FETCH;
          end
        end
      end
`ifdef OTTER_DUMP_CHECKSUM_EN
      CKSUM: begin
        // First cycle here loads the checksum beat, then wait for its handshake
        if (!bus.DOUT_VALID) begin
          w_load    = 1'b1;
          w_ld_data = r_acc;
          w_ld_idx  = '0;
          w_ld_last = 1'b1;
        end else if (w_accept) begin
          w_next = FIN;
        end
      end
`endif
      FIN:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
    if (bus.ABORT) begin
      w_next  = IDLE;
      w_load  = 1'b0;
      w_latch = 1'b0;
      w_inc   = 1'b0;
    end
  end

  // DONE is registered so it pulses on the cycle after FIN
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_state <= IDLE;
      r_cur   <= '0;
      r_end   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= (r_state == FIN) && !bus.ABORT;
      if (w_latch) begin
        r_cur <= bus.START_FIRST;
        r_end <= bus.START_LAST;
      end else if (w_inc) begin
        r_cur <= r_cur + 1'b1;
      end
    end
  end

`ifdef OTTER_DUMP_CHECKSUM_EN
  always_ff @(posedge CLK) begin
    if (!RST_N || bus.ABORT || w_latch) begin
      r_acc <= '0;
    end else if (r_state == SEND && w_accept) begin
      r_acc <= r_acc ^ bus.DOUT_DATA;
    end
  end
`endif

  assign bus.RF_ADDR = (r_state == IDLE) ? '0 : r_cur;
  assign bus.BUSY    = (r_state != IDLE);
  assign bus.DONE    = r_done;

  otter_stream_reg #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_stream (
    .i_clk    (CLK),
    .i_rst_n  (RST_N),
    .i_load   (w_load),
    .i_accept (w_accept),
    .i_flush  (bus.ABORT),
    .i_data   (w_ld_data),
    .i_idx    (w_ld_idx),
    .i_last   (w_ld_last),
    .o_valid  (bus.DOUT_VALID),
    .o_data   (bus.DOUT_DATA),
    .o_idx    (bus.DOUT_IDX),
    .o_last   (bus.DOUT_LAST)
  );
endmodule

// File: tb/tb_otter_regfile_dumper.sv
// Scoreboard bench for otter_regfile_dumper; expected beats are queued at START.
// Defining OTTER_DUMP_CHECKSUM_EN also expects and tests the checksum beat.
module tb_otter_regfile_dumper;
  localparam int AW = 5;
  localparam int DW = 32;
`ifdef OTTER_DUMP_CHECKSUM_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif

  typedef struct packed {
    logic [DW-1:0] data;
    logic [AW-1:0] idx;
    logic          last;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  otter_regfile_dumper_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  otter_regfile_dumper #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (bus)
  );

  // Register file read port model: combinational, index 0 reads zero
  logic [DW-1:0] rf [32];
  assign bus.RF_DATA = (bus.RF_ADDR == '0) ? '0 : rf[bus.RF_ADDR];

  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  int    beats_seen = 0;
  int    done_cnt = 0;
  int    done_cyc = 0;
  int    last_acc_cyc = 0;
  int    acc_cyc_q[$];
  beat_t exp_q[$];
  beat_t m_got;
  beat_t m_exp;

  always @(posedge clk) cyc++;

  // Beats are taken at the negedge before the accepting posedge
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.DOUT_VALID && bus.DOUT_READY) begin
        m_got = {bus.DOUT_DATA, bus.DOUT_IDX, bus.DOUT_LAST};
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL beat_unexpected got idx=%0d data=%h last=%0b required no beat",
                   m_got.idx, m_got.data, m_got.last);
        end else begin
          m_exp = exp_q.pop_front();
          if (m_got !== m_exp) begin
            errors++;
            $display("[TB] FAIL beat got idx=%0d data=%h last=%0b required idx=%0d data=%h last=%0b",
                     m_got.idx, m_got.data, m_got.last, m_exp.idx, m_exp.data, m_exp.last);
          end
        end
        beats_seen++;
        last_acc_cyc = cyc;
        acc_cyc_q.push_back(cyc);
      end
      if (bus.DONE) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_dump(input logic [AW-1:0] first, input logic [AW-1:0] last_i);
    logic [AW-1:0] n_m1;
    logic [AW-1:0] idx;
    logic [DW-1:0] acc;
    logic [DW-1:0] d;
    beat_t         b;
    n_m1 = last_i - first;
    idx  = first;
    acc  = '0;
    for (int k = 0; k <= int'(n_m1); k++) begin
      d = (idx == '0) ? '0 : rf[idx];
      acc = acc ^ d;
      b.data = d;
      b.idx  = idx;
`ifdef OTTER_DUMP_CHECKSUM_EN
      b.last = 1'b0;
`else
      b.last = (k == int'(n_m1));
`endif
      exp_q.push_back(b);
      idx = idx + 1'b1;
    end
`ifdef OTTER_DUMP_CHECKSUM_EN
    b.data = acc;
    b.idx  = '0;
    b.last = 1'b1;
    exp_q.push_back(b);
`endif
  endtask

  task automatic start_dump(input logic [AW-1:0] first, input logic [AW-1:0] last_i);
    bus.START_FIRST = first;
    bus.START_LAST  = last_i;
    bus.START       = 1'b1;
    push_dump(first, last_i);
    tick();
    bus.START = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    int d0;
    d0 = done_cnt;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (done_cnt > d0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    bus.START = 1'b0;
    bus.ABORT = 1'b0;
    bus.DOUT_READY = 1'b1;
    bus.START_FIRST = '0;
    bus.START_LAST = '0;
    rst_n = 1'b0;
    repeat (3) tick();
    checks += 7;
    if (bus.RF_ADDR !== '0) begin errors++; $display("[TB] FAIL reset_rf_addr got %0d required 0", bus.RF_ADDR); end
    if (bus.DOUT_VALID !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %0b required 0", bus.DOUT_VALID); end
    if (bus.DOUT_DATA !== '0) begin errors++; $display("[TB] FAIL reset_data got %h required 0", bus.DOUT_DATA); end
    if (bus.DOUT_IDX !== '0) begin errors++; $display("[TB] FAIL reset_idx got %0d required 0", bus.DOUT_IDX); end
    if (bus.DOUT_LAST !== 1'b0) begin errors++; $display("[TB] FAIL reset_last got %0b required 0", bus.DOUT_LAST); end
    if (bus.BUSY !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %0b required 0", bus.BUSY); end
    if (bus.DONE !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got %0b required 0", bus.DONE); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    int b0;
    int n;
    bit ok;
    b0 = beats_seen;
    start_dump(5'd5, 5'd5);
    n = 1;
    checks++;
    if (bus.BUSY !== 1'b1) begin errors++; $display("[TB] FAIL single_busy got %0b required 1", bus.BUSY); end
    while (bus.DOUT_VALID !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    checks++;
    if (n != 2) begin errors++; $display("[TB] FAIL single_latency got %0d required 2", n); end
    wait_done(30, ok);
    checks++;
    if (!ok) begin errors++; $display("[TB] FAIL single_done got timeout required pulse"); end
    checks++;
    if (done_cyc - last_acc_cyc != 2) begin
      errors++; $display("[TB] FAIL single_done_latency got %0d required 2", done_cyc - last_acc_cyc);
    end
    checks++;
    if (bus.DONE !== 1'b0) begin errors++; $display("[TB] FAIL single_done_width got %0b required 0", bus.DONE); end
    checks++;
    if (beats_seen - b0 != 1 + EXTRA) begin
      errors++; $display("[TB] FAIL single_count got %0d required %0d", beats_seen - b0, 1 + EXTRA);
    end
  endtask

  task automatic test_full_dump();
    int b0;
    int d0;
    int ai;
    int busy_low;
    int bad_gap;
    bit ok;
    for (int i = 0; i < 32; i++) rf[i] = i * 32'h0101_0101;
    b0 = beats_seen;
    d0 = done_cnt;
    ai = acc_cyc_q.size();
    busy_low = 0;
    bad_gap = 0;
    ok = 1'b0;
    start_dump(5'd0, 5'd31);
    for (int i = 0; i < 200; i++) begin
      if (done_cnt > d0) begin
        ok = 1'b1;
        break;
      end
      if (bus.DONE === 1'b0 && bus.BUSY !== 1'b1) busy_low++;
      tick();
    end
    checks++;
    if (!ok) begin errors++; $display("[TB] FAIL full_done got timeout required pulse"); end
    checks++;
    if (busy_low != 0) begin errors++; $display("[TB] FAIL full_busy got %0d low cycles required 0", busy_low); end
    checks++;
    if (beats_seen - b0 != 32 + EXTRA) begin
      errors++; $display("[TB] FAIL full_count got %0d required %0d", beats_seen - b0, 32 + EXTRA);
    end
    if (acc_cyc_q.size() >= ai + 32) begin
      for (int j = ai + 1; j < ai + 32; j++) if (acc_cyc_q[j] - acc_cyc_q[j-1] != 2) bad_gap++;
    end else begin
      bad_gap = 99;
    end
    checks++;
    if (bad_gap != 0) begin errors++; $display("[TB] FAIL full_rate got %0d bad gaps required 0", bad_gap); end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("[TB] FAIL full_pending got %0d required 0", exp_q.size()); end
  endtask

  task automatic test_wrap();
    int b0;
    bit ok;
    b0 = beats_seen;
    start_dump(5'd30, 5'd1);
    wait_done(60, ok);
    checks++;
    if (!ok) begin errors++; $display("[TB] FAIL wrap_done got timeout required pulse"); end
    checks++;
    if (beats_seen - b0 != 4 + EXTRA) begin
      errors++; $display("[TB] FAIL wrap_count got %0d required %0d", beats_seen - b0, 4 + EXTRA);
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("[TB] FAIL wrap_pending got %0d required 0", exp_q.size()); end
  endtask

  task automatic test_backpressure();
    int    b0;
    bit    found;
    bit    ok;
    beat_t snap;
    beat_t now_b;
    b0 = beats_seen;
    found = 1'b0;
    start_dump(5'd0, 5'd5);
    for (int i = 0; i < 40; i++) begin
      if (bus.DOUT_VALID === 1'b1 && bus.DOUT_IDX === 5'd3) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    checks++;
    if (!found) begin errors++; $display("[TB] FAIL bp_reach got timeout required idx 3"); end
    bus.DOUT_READY = 1'b0;
    snap = {bus.DOUT_DATA, bus.DOUT_IDX, bus.DOUT_LAST};
    checks++;
    if (snap.data !== 32'h0303_0303) begin
      errors++; $display("[TB] FAIL bp_data got %h required 03030303", snap.data);
    end
    @(negedge clk);
    rf[3] = 32'h1234_5678;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (i == 1) begin
        bus.START_FIRST = 5'd9;
        bus.START_LAST  = 5'd9;
        bus.START       = 1'b1;
      end else begin
        bus.START = 1'b0;
      end
      now_b = {bus.DOUT_DATA, bus.DOUT_IDX, bus.DOUT_LAST};
      checks++;
      if (now_b !== snap || bus.DOUT_VALID !== 1'b1) begin
        errors++;
        $display("[TB] FAIL bp_hold got idx=%0d data=%h valid=%0b required idx=%0d data=%h valid=1",
                 now_b.idx, now_b.data, bus.DOUT_VALID, snap.idx, snap.data);
      end
    end
    bus.START = 1'b0;
    bus.DOUT_READY = 1'b1;
    wait_done(60, ok);
    checks++;
    if (!ok) begin errors++; $display("[TB] FAIL bp_done got timeout required pulse"); end
    checks++;
    if (beats_seen - b0 != 6 + EXTRA) begin
      errors++; $display("[TB] FAIL bp_count got %0d required %0d", beats_seen - b0, 6 + EXTRA);
    end
    rf[3] = 32'h0303_0303;
  endtask

  task automatic test_abort();
    int b0;
    int d0;
    bit found;
    bit ok;
    found = 1'b0;
    start_dump(5'd0, 5'd31);
    for (int i = 0; i < 60; i++) begin
      if (bus.DOUT_VALID === 1'b1 && bus.DOUT_IDX === 5'd7) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    checks++;
    if (!found) begin errors++; $display("[TB] FAIL abort_reach got timeout required idx 7"); end
    bus.DOUT_READY = 1'b0;
    bus.ABORT = 1'b1;
    d0 = done_cnt;
    tick();
    bus.ABORT = 1'b0;
    checks += 3;
    if (bus.DOUT_VALID !== 1'b0) begin errors++; $display("[TB] FAIL abort_valid got %0b required 0", bus.DOUT_VALID); end
    if (bus.BUSY !== 1'b0) begin errors++; $display("[TB] FAIL abort_busy got %0b required 0", bus.BUSY); end
    if (bus.DOUT_LAST !== 1'b0) begin errors++; $display("[TB] FAIL abort_last got %0b required 0", bus.DOUT_LAST); end
    exp_q.delete();
    bus.DOUT_READY = 1'b1;
    repeat (4) tick();
    checks++;
    if (done_cnt != d0) begin errors++; $display("[TB] FAIL abort_no_done got %0d required 0", done_cnt - d0); end
    b0 = beats_seen;
    start_dump(5'd2, 5'd2);
    wait_done(30, ok);
    checks++;
    if (!ok) begin errors++; $display("[TB] FAIL abort_restart got timeout required pulse"); end
    checks++;
    if (beats_seen - b0 != 1 + EXTRA) begin
      errors++; $display("[TB] FAIL abort_restart_count got %0d required %0d", beats_seen - b0, 1 + EXTRA);
    end
  endtask

  task automatic test_reset_mid();
    start_dump(5'd0, 5'd31);
    repeat (6) tick();
    rst_n = 1'b0;
    tick();
    checks++;
    if ({bus.RF_ADDR, bus.DOUT_VALID, bus.DOUT_DATA, bus.DOUT_IDX, bus.DOUT_LAST, bus.BUSY, bus.DONE} !== '0) begin
      errors++;
      $display("[TB] FAIL midreset_outputs got addr=%0d v=%0b d=%h i=%0d l=%0b b=%0b dn=%0b required all 0",
               bus.RF_ADDR, bus.DOUT_VALID, bus.DOUT_DATA, bus.DOUT_IDX, bus.DOUT_LAST, bus.BUSY, bus.DONE);
    end
    exp_q.delete();
    rst_n = 1'b1;
    tick();
  endtask

`ifdef OTTER_DUMP_CHECKSUM_EN
  task automatic test_checksum();
    int b0;
    bit ok;
    rf[1] = 32'hF0F0_F0F0;
    rf[2] = 32'h0F0F_00FF;
    b0 = beats_seen;
    start_dump(5'd1, 5'd2);
    wait_done(40, ok);
    checks++;
    if (!ok) begin errors++; $display("[TB] FAIL cksum_done got timeout required pulse"); end
    checks++;
    if (beats_seen - b0 != 3) begin errors++; $display("[TB] FAIL cksum_count got %0d required 3", beats_seen - b0); end
    checks++;
    if (m_got !== {32'hFFFF_F00F, 5'd0, 1'b1}) begin
      errors++;
      $display("[TB] FAIL cksum_beat got idx=%0d data=%h last=%0b required idx=0 data=fffff00f last=1",
               m_got.idx, m_got.data, m_got.last);
    end
  endtask
`endif

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = '0;
    rf[5] = 32'hDEAD_BEEF;
    test_reset();
    test_single();
    test_full_dump();
    test_wrap();
    test_backpressure();
    test_abort();
    test_reset_mid();
`ifdef OTTER_DUMP_CHECKSUM_EN
    test_checksum();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
